// File: rtl/llc_snoop_responder_pkg.sv
// Shared types for the LLC snoop responder: bus-op and MESI encodings,
// snoop result codes, the per-lookup decision bundle and address geometry.
package llc_snoop_responder_pkg;

    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 6;
    localparam int INDEX_W  = 14;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WAY_W    = 3;
    localparam int LINE_W   = ADDR_W - OFFSET_W;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_READ  = 3'd1,
        OP_WRITE = 3'd2,
        OP_INVAL = 3'd3,
        OP_RWIM  = 3'd4
    } bus_op_e;

    typedef enum logic [1:0] {
        MESI_M = 2'd0,
        MESI_E = 2'd1,
        MESI_S = 2'd2,
        MESI_I = 2'd3
    } mesi_e;

    localparam logic [1:0] SNP_HIT   = 2'd0;
    localparam logic [1:0] SNP_HITM  = 2'd1;
    localparam logic [1:0] SNP_NOHIT = 2'd2;

    typedef struct packed {
        logic [1:0] result;
        mesi_e      next_state;
        logic       wb;
        logic       inval;
        logic       err;
    } snoop_dec_t;

    function automatic logic [ADDR_W-1:0] line_base(
        input logic [LINE_W-1:0] line
    );
        return {line, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/llc_snoop_responder_if.sv
// Snoop-side bundle: bus op in/ready out, tag store lookup/update,
// writeback handshake, snoop result and L1 invalidate. slave = responder.
interface llc_snoop_responder_if;
    import llc_snoop_responder_pkg::*;

    logic               bus_valid;
    logic [2:0]         bus_op;
    logic [ADDR_W-1:0]  bus_addr;
    logic               bus_ready;
    logic               tag_rd_en;
    logic [INDEX_W-1:0] tag_rd_index;
    logic [TAG_W-1:0]   tag_rd_tag;
    logic               tag_rd_hit;
    logic [WAY_W-1:0]   tag_rd_way;
    logic [1:0]         tag_rd_state;
    logic               tag_wr_en;
    logic [INDEX_W-1:0] tag_wr_index;
    logic [WAY_W-1:0]   tag_wr_way;
    logic [1:0]         tag_wr_state;
    logic               wb_valid;
    logic [ADDR_W-1:0]  wb_addr;
    logic               wb_ready;
    logic               snoop_valid;
    logic [1:0]         snoop_result;
    logic               l1_inval_valid;
    logic [ADDR_W-1:0]  l1_inval_addr;
    logic               protocol_err;

    modport slave (
        input  bus_valid, bus_op, bus_addr,
        input  tag_rd_hit, tag_rd_way, tag_rd_state,
        input  wb_ready,
        output bus_ready, tag_rd_en, tag_rd_index, tag_rd_tag,
        output tag_wr_en, tag_wr_index, tag_wr_way, tag_wr_state,
        output wb_valid, wb_addr,
        output snoop_valid, snoop_result,
        output l1_inval_valid, l1_inval_addr, protocol_err
    );

    modport master (
        output bus_valid, bus_op, bus_addr,
        output tag_rd_hit, tag_rd_way, tag_rd_state,
        output wb_ready,
        input  bus_ready, tag_rd_en, tag_rd_index, tag_rd_tag,
        input  tag_wr_en, tag_wr_index, tag_wr_way, tag_wr_state,
        input  wb_valid, wb_addr,
        input  snoop_valid, snoop_result,
        input  l1_inval_valid, l1_inval_addr, protocol_err
    );

endinterface

// File: rtl/llc_snoop_responder_mesi_snoop_next.sv
// Combinational snoop decision: (op, hit, MESI state) -> result,
// next state, writeback, L1 invalidate and protocol error flags.
module mesi_snoop_next
    import llc_snoop_responder_pkg::*;
(
    input  logic [2:0] op_i,
    input  logic       hit_i,
    input  mesi_e      state_i,
    output snoop_dec_t dec_o
);

    logic present;
    logic dirty;

    // A hit on an Invalid way is the same as a miss.
    assign present = hit_i && (state_i != MESI_I);
    assign dirty   = (state_i == MESI_M);

    always_comb begin
        dec_o.result     = SNP_NOHIT;
        dec_o.next_state = state_i;
        dec_o.wb         = 1'b0;
        dec_o.inval      = 1'b0;
        dec_o.err        = 1'b0;
        unique case (1'b1)
            (op_i == OP_READ): begin
                if (present) begin
                    dec_o.result     = dirty ? SNP_HITM : SNP_HIT;
                    dec_o.next_state = MESI_S;
                    dec_o.wb         = dirty;
                end
            end
            (op_i == OP_RWIM): begin
                if (present) begin
                    dec_o.result     = dirty ? SNP_HITM : SNP_HIT;
                    dec_o.next_state = MESI_I;
                    dec_o.wb         = dirty;
                    dec_o.inval      = 1'b1;
                end
            end
            (op_i == OP_INVAL): begin
                // An invalidate is only legal against a shared copy.
                if (present) begin
                    if (state_i == MESI_S) begin
                        dec_o.result     = SNP_HIT;
                        dec_o.next_state = MESI_I;
                        dec_o.inval      = 1'b1;
                    end else begin
                        dec_o.err = 1'b1;
                    end
                end
            end
            (op_i == OP_WRITE): begin
                // Only an owner may write back; we must not hold a copy.
                dec_o.err = present;
            end
            default: begin
                dec_o.err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/llc_snoop_responder.sv
// LLC snoop responder: accepts a snooped bus op, looks it up, flushes
// dirty data, reports HIT/HITM/NOHIT and applies the MESI update.
// Ports: clk, rst (async active-high), sif (slave side of the bundle).
module llc_snoop_responder
    import llc_snoop_responder_pkg::*;
(
    input  logic clk,
    input  logic rst,
    llc_snoop_responder_if.slave sif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_DECIDE,
        S_WB,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q;
    logic [LINE_W-1:0] line_q;
    snoop_dec_t        dec_q;
    snoop_dec_t        dec;
    logic              upd_q;
    logic [WAY_W-1:0]  way_q;
    logic              accept;

    assign accept = (state_q == S_IDLE) && sif.bus_valid;

    mesi_snoop_next u_next (
        .op_i    (op_q),
        .hit_i   (sif.tag_rd_hit),
        .state_i (mesi_e'(sif.tag_rd_state)),
        .dec_o   (dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            line_q  <= '0;
            dec_q   <= '{SNP_NOHIT, MESI_I, 1'b0, 1'b0, 1'b0};
            upd_q   <= 1'b0;
            way_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= sif.bus_op;
                line_q <= sif.bus_addr[ADDR_W-1:OFFSET_W];
            end
            if (state_q == S_DECIDE) begin
                dec_q <= dec;
                way_q <= sif.tag_rd_way;
                // Write the tag store only on a real state change.
                upd_q <= sif.tag_rd_hit &&
                         (dec.next_state != mesi_e'(sif.tag_rd_state));
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        sif.bus_ready      = 1'b0;
        sif.tag_rd_en      = 1'b0;
        sif.tag_rd_index   = '0;
        sif.tag_rd_tag     = '0;
        sif.tag_wr_en      = 1'b0;
        sif.tag_wr_index   = '0;
        sif.tag_wr_way     = '0;
        sif.tag_wr_state   = 2'd0;
        sif.wb_valid       = 1'b0;
        sif.wb_addr        = '0;
        sif.snoop_valid    = 1'b0;
        sif.snoop_result   = SNP_NOHIT;
        sif.l1_inval_valid = 1'b0;
        sif.l1_inval_addr  = '0;
        sif.protocol_err   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                sif.bus_ready = 1'b1;
                if (sif.bus_valid) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                sif.tag_rd_en    = 1'b1;
                sif.tag_rd_index = line_q[INDEX_W-1:0];
                sif.tag_rd_tag   = line_q[LINE_W-1:INDEX_W];
                state_d          = S_DECIDE;
            end
            S_DECIDE: begin
                state_d = dec.wb ? S_WB : S_RESP;
            end
            S_WB: begin
                sif.wb_valid = 1'b1;
                sif.wb_addr  = line_base(line_q);
                if (sif.wb_ready) state_d = S_RESP;
            end
            S_RESP: begin
                sif.snoop_valid  = 1'b1;
                sif.snoop_result = dec_q.result;
                sif.protocol_err = dec_q.err;
                if (upd_q) begin
                    sif.tag_wr_en    = 1'b1;
                    sif.tag_wr_index = line_q[INDEX_W-1:0];
                    sif.tag_wr_way   = way_q;
                    sif.tag_wr_state = dec_q.next_state;
                end
                if (dec_q.inval) begin
                    sif.l1_inval_valid = 1'b1;
                    sif.l1_inval_addr  = line_base(line_q);
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_llc_snoop_responder.sv
// Self-checking bench for llc_snoop_responder: directed scenarios plus
// randomized ops compared cycle by cycle against a transaction timeline.
module tb_llc_snoop_responder;
    import llc_snoop_responder_pkg::*;

    typedef struct {
        int res; int nst; bit wb; bit inv; bit err;
    } row_t;

    typedef struct {
        int a; int r; int op; logic [31:0] addr;
        bit hit; int way; int st; int d;
        int res; int nst; bit wb; bit inv; bit err;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    llc_snoop_responder_if sif();

    llc_snoop_responder dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    always #5 clk = ~clk;

    row_t tab [8][4];
    txn_t cur;
    bit   cur_v = 1'b0;
    bit   chk_en = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    int n_sv = 0, n_wb = 0, n_wr = 0, n_inv = 0, n_err = 0, n_rd = 0;
    int b_sv, b_wb, b_wr, b_inv, b_err, b_rd;
    int last_res, last_wr_state, last_wr_way;
    logic [31:0] last_wb_addr, last_inv_addr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    // Snoop rules as a table indexed by [op][effective MESI state].
    task automatic fill_table();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 4; j++)
                tab[i][j] = '{2, j, 1'b0, 1'b0, bit'(i == 0 || i >= 5)};
        tab[1][0] = '{1, 2, 1'b1, 1'b0, 1'b0};
        tab[1][1] = '{0, 2, 1'b0, 1'b0, 1'b0};
        tab[1][2] = '{0, 2, 1'b0, 1'b0, 1'b0};
        for (int j = 0; j < 3; j++)
            tab[2][j] = '{2, j, 1'b0, 1'b0, 1'b1};
        tab[3][0] = '{2, 0, 1'b0, 1'b0, 1'b1};
        tab[3][1] = '{2, 1, 1'b0, 1'b0, 1'b1};
        tab[3][2] = '{0, 3, 1'b0, 1'b1, 1'b0};
        tab[4][0] = '{1, 3, 1'b1, 1'b1, 1'b0};
        tab[4][1] = '{0, 3, 1'b0, 1'b1, 1'b0};
        tab[4][2] = '{0, 3, 1'b0, 1'b1, 1'b0};
    endtask

    task automatic snap();
        b_sv = n_sv; b_wb = n_wb; b_wr = n_wr;
        b_inv = n_inv; b_err = n_err; b_rd = n_rd;
    endtask

    // Present an op and hold it until accepted; returns one cycle later
    // with bus_valid still high so a following call models a held op.
    task automatic issue(input int op, input logic [31:0] addr,
                         input bit hit, input int way, input int st,
                         input int d);
        txn_t t;
        int   es;
        bit   ok;
        sif.bus_valid = 1'b1;
        sif.bus_op    = 3'(op);
        sif.bus_addr  = addr;
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (sif.bus_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout cyc=%0d got=0 exp=1", cyc);
            sif.bus_valid = 1'b0;
            return;
        end
        es = hit ? st : 3;
        t.a = cyc + 1; t.op = op; t.addr = addr; t.hit = hit;
        t.way = way; t.st = st; t.d = d;
        t.res = tab[op][es].res; t.nst = tab[op][es].nst;
        t.wb = tab[op][es].wb; t.inv = tab[op][es].inv;
        t.err = tab[op][es].err;
        t.r = t.a + 2 + (t.wb ? d + 1 : 0);
        cur = t;
        cur_v = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        sif.bus_valid = 1'b0;
        sif.bus_op    = 3'($urandom);
        sif.bus_addr  = $urandom;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 200; k++) begin
            if (!cur_v || cyc > cur.r + 1) break;
            @(negedge clk);
        end
    endtask

    // Tag store and writeback-sink responder.
    initial forever begin
        @(negedge clk);
        if (cur_v && cyc == cur.a + 1) begin
            sif.tag_rd_hit   = cur.hit;
            sif.tag_rd_way   = 3'(cur.way);
            sif.tag_rd_state = 2'(cur.st);
        end else begin
            sif.tag_rd_hit   = 1'($urandom);
            sif.tag_rd_way   = 3'($urandom);
            sif.tag_rd_state = 2'($urandom);
        end
        if (cur_v && cur.wb && cyc >= cur.a + 2 && cyc <= cur.r)
            sif.wb_ready = (cyc >= cur.a + 2 + cur.d);
        else
            sif.wb_ready = 1'($urandom);
    end

    // Event monitor for the directed literal expectations.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (sif.tag_rd_en) n_rd++;
            if (sif.snoop_valid) begin
                n_sv++;
                last_res = int'(sif.snoop_result);
            end
            if (sif.wb_valid) begin
                n_wb++;
                last_wb_addr = sif.wb_addr;
            end
            if (sif.tag_wr_en) begin
                n_wr++;
                last_wr_state = int'(sif.tag_wr_state);
                last_wr_way   = int'(sif.tag_wr_way);
            end
            if (sif.l1_inval_valid) begin
                n_inv++;
                last_inv_addr = sif.l1_inval_addr;
            end
            if (sif.protocol_err) n_err++;
        end
    end

    // Per-cycle comparison against the transaction timeline.
    initial forever begin
        bit act, e_rd, e_wb, e_sv, e_wr, e_inv, e_err;
        logic [31:0] line;
        @(negedge clk);
        if (chk_en && !rst) begin
            act   = cur_v && cyc >= cur.a && cyc <= cur.r;
            e_rd  = act && cyc == cur.a;
            e_wb  = act && cur.wb && cyc >= cur.a + 2 && cyc < cur.r;
            e_sv  = act && cyc == cur.r;
            e_wr  = e_sv && cur.hit && cur.nst != cur.st;
            e_inv = e_sv && cur.inv;
            e_err = e_sv && cur.err;
            line  = {cur.addr[31:6], 6'b0};
            chk("bus_ready", 32'(sif.bus_ready), 32'(!act));
            chk("tag_rd_en", 32'(sif.tag_rd_en), 32'(e_rd));
            chk("wb_valid", 32'(sif.wb_valid), 32'(e_wb));
            chk("snoop_valid", 32'(sif.snoop_valid), 32'(e_sv));
            chk("tag_wr_en", 32'(sif.tag_wr_en), 32'(e_wr));
            chk("l1_inval_valid", 32'(sif.l1_inval_valid), 32'(e_inv));
            chk("protocol_err", 32'(sif.protocol_err), 32'(e_err));
            if (e_rd) begin
                chk("tag_rd_index", 32'(sif.tag_rd_index),
                    32'(cur.addr[19:6]));
                chk("tag_rd_tag", 32'(sif.tag_rd_tag),
                    32'(cur.addr[31:20]));
            end
            if (e_wb) chk("wb_addr", sif.wb_addr, line);
            if (e_sv) chk("snoop_result", 32'(sif.snoop_result), cur.res);
            if (e_wr) begin
                chk("tag_wr_index", 32'(sif.tag_wr_index),
                    32'(cur.addr[19:6]));
                chk("tag_wr_way", 32'(sif.tag_wr_way), cur.way);
                chk("tag_wr_state", 32'(sif.tag_wr_state), cur.nst);
            end
            if (e_inv) chk("l1_inval_addr", sif.l1_inval_addr, line);
        end
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_bus_ready"}, 32'(sif.bus_ready), 1);
        chk({tag, "_tag_rd_en"}, 32'(sif.tag_rd_en), 0);
        chk({tag, "_tag_rd_index"}, 32'(sif.tag_rd_index), 0);
        chk({tag, "_tag_wr_en"}, 32'(sif.tag_wr_en), 0);
        chk({tag, "_wb_valid"}, 32'(sif.wb_valid), 0);
        chk({tag, "_wb_addr"}, sif.wb_addr, 0);
        chk({tag, "_snoop_valid"}, 32'(sif.snoop_valid), 0);
        chk({tag, "_snoop_result"}, 32'(sif.snoop_result), 2);
        chk({tag, "_l1_inval"}, 32'(sif.l1_inval_valid), 0);
        chk({tag, "_protocol_err"}, 32'(sif.protocol_err), 0);
    endtask

    initial begin
        int op, r;
        fill_table();
        sif.bus_valid = 1'b0;
        sif.bus_op    = 3'd0;
        sif.bus_addr  = '0;
        sif.wb_ready  = 1'b0;
        sif.tag_rd_hit = 1'b0;
        sif.tag_rd_way = '0;
        sif.tag_rd_state = 2'd0;
        #1;
        chk_idle_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // READ hitting a Modified line, writeback sink always ready.
        #1 snap();
        issue(1, 32'h0001_2340, 1'b1, 5, 0, 0);
        idle(0);
        wait_done();
        #1;
        chk("t1_snoop_cnt", n_sv - b_sv, 1);
        chk("t1_wb_cnt", n_wb - b_wb, 1);
        chk("t1_wb_addr", last_wb_addr, 32'h0001_2340);
        chk("t1_result", last_res, 1);
        chk("t1_wr_way", last_wr_way, 5);
        chk("t1_wr_state", last_wr_state, 2);
        chk("t1_inval_cnt", n_inv - b_inv, 0);

        // RWIM hitting an Exclusive line in way 2.
        @(negedge clk);
        #1 snap();
        issue(4, 32'h0ABC_DE7F, 1'b1, 2, 1, 0);
        idle(0);
        wait_done();
        #1;
        chk("t2_result", last_res, 0);
        chk("t2_wr_state", last_wr_state, 3);
        chk("t2_wr_way", last_wr_way, 2);
        chk("t2_inval_cnt", n_inv - b_inv, 1);
        chk("t2_inval_addr", last_inv_addr, 32'h0ABC_DE40);
        chk("t2_wb_cnt", n_wb - b_wb, 0);

        // INVALIDATE against a Modified line is a protocol error.
        @(negedge clk);
        #1 snap();
        issue(3, 32'h1234_5680, 1'b1, 7, 0, 0);
        idle(0);
        wait_done();
        #1;
        chk("t3_result", last_res, 2);
        chk("t3_err_cnt", n_err - b_err, 1);
        chk("t3_wr_cnt", n_wr - b_wr, 0);

        // READ miss followed by a READ held on the bus while busy.
        @(negedge clk);
        #1 snap();
        issue(1, 32'h0000_1000, 1'b0, 0, 0, 0);
        issue(1, 32'h0000_2040, 1'b1, 4, 2, 0);
        idle(0);
        wait_done();
        #1;
        chk("t4_rd_cnt", n_rd - b_rd, 2);
        chk("t4_snoop_cnt", n_sv - b_sv, 2);
        chk("t4_result2", last_res, 0);
        chk("t4_wr_cnt", n_wr - b_wr, 0);

        // RWIM on Modified with the writeback sink stalling 5 cycles.
        @(negedge clk);
        #1 snap();
        issue(4, 32'hFEDC_BA98, 1'b1, 6, 0, 5);
        idle(0);
        wait_done();
        #1;
        chk("t5_wb_cycles", n_wb - b_wb, 6);
        chk("t5_result", last_res, 1);
        chk("t5_inval_cnt", n_inv - b_inv, 1);

        // Reset asserted in the middle of a writeback.
        @(negedge clk);
        issue(1, 32'h0F0F_0F00, 1'b1, 3, 0, 20);
        idle(0);
        for (int k = 0; k < 10; k++) begin
            if (sif.wb_valid === 1'b1) break;
            @(negedge clk);
        end
        chk("t6_wb_seen", 32'(sif.wb_valid), 1);
        #2 rst = 1'b1;
        #1 cur_v = 1'b0;
        chk_idle_outputs("t6_rst");
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 snap();
        repeat (8) @(negedge clk);
        #1;
        chk("t6_snoop_cnt", n_sv - b_sv, 0);
        chk("t6_wr_cnt", n_wr - b_wr, 0);
        chk("t6_wb_cnt", n_wb - b_wb, 0);

        // Randomized ops, sometimes held back-to-back.
        @(negedge clk);
        for (int i = 0; i < 80; i++) begin
            r  = $urandom_range(0, 9);
            op = (r < 8) ? (r % 4) + 1 :
                 (r == 8) ? 0 : $urandom_range(5, 7);
            issue(op, $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 3),
                  $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0)
                idle($urandom_range(0, 3));
        end
        idle(0);
        wait_done();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/llc_snoop_responder.md
Name: llc_snoop_responder

Overview:
- Snoop-side responder for the last-level cache.
- Watches bus operations issued by other caches on the shared bus and looks up the snooped line in the LLC tag/MESI store.
- Returns the snoop result (HIT/HITM/NOHIT), flushes modified data when required, applies the MESI transition and tells L1 to drop lines that become Invalid.
- This is the receiving end of the bus-op/snoop-result exchange the LLC performs as initiator.

Parameters:
- ADDR_W, 32, bus address width
- OFFSET_W, 6, byte-select bits (64 B line)
- INDEX_W, 14, set index bits
- TAG_W, ADDR_W-INDEX_W-OFFSET_W (12), tag bits
- WAY_W, 3, way select width (8 ways)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- bus_valid  in  1  snooped bus operation present
- bus_op  in  3  1=READ, 2=WRITE, 3=INVALIDATE, 4=RWIM
- bus_addr  in  ADDR_W  snooped address
- bus_ready  out  1  responder idle, can accept
- tag_rd_en  out  1  tag lookup request (1-cycle pulse)
- tag_rd_index  out  INDEX_W  lookup set
- tag_rd_tag  out  TAG_W  lookup tag
- tag_rd_hit  in  1  lookup hit, valid the cycle after tag_rd_en
- tag_rd_way  in  WAY_W  hitting way
- tag_rd_state  in  2  MESI state of hitting way (M=0, E=1, S=2, I=3)
- tag_wr_en  out  1  state update strobe
- tag_wr_index  out  INDEX_W  update set
- tag_wr_way  out  WAY_W  update way
- tag_wr_state  out  2  new MESI state
- wb_valid  out  1  writeback (flush) request to bus
- wb_addr  out  ADDR_W  line-aligned flush address
- wb_ready  in  1  bus accepts writeback
- snoop_valid  out  1  snoop result strobe
- snoop_result  out  2  HIT=0, HITM=1, NOHIT=2
- l1_inval_valid  out  1  tell L1 to invalidate line
- l1_inval_addr  out  ADDR_W  line-aligned address
- protocol_err  out  1  1-cycle pulse on illegal op/state combination

Behaviour:
- Reset (async, rst=1):
  - FSM→IDLE; bus_ready=1; all other outputs 0, except snoop_result=NOHIT(2).
  - In-flight operation and pending writeback are discarded.
- Accept: bus_valid && bus_ready at a rising edge latches op, addr; bus_ready drops the next cycle. bus_ready=1 only in IDLE.
- FSM IDLE→LOOKUP→DECIDE→[WB]→RESP→IDLE.
  - LOOKUP: tag_rd_en=1 for exactly one cycle with index/tag from the latched addr.
  - DECIDE: sample tag_rd_hit/way/state; compute result, next state, wb_needed, inval_needed; register them.
  - WB: wb_valid=1 with wb_addr (offset bits zeroed), held until wb_ready sampled 1. wb_ready already high on the first WB cycle costs one cycle.
  - RESP: snoop_valid=1 for one cycle. tag_wr_en=1 in the same cycle only if state changes. l1_inval_valid=1 in the same cycle if the line goes to I.
- Latency: snoop_valid 3 cycles after the accept edge without writeback; 3+N with writeback, where N = cycles in WB.
- Miss or state I: NOHIT, no update, no writeback, no error.
- READ:
  - M→S, HITM, writeback.
  - E→S, HIT.
  - S→S, HIT, no write.
- RWIM:
  - M→I, HITM, writeback, L1 inval.
  - E/S→I, HIT, L1 inval.
- INVALIDATE:
  - S→I, HIT, L1 inval.
  - M or E: protocol_err pulse, state unchanged, NOHIT.
- WRITE (another cache's writeback): NOHIT, no update. A hit in M/E/S raises protocol_err.
- bus_op 0 or ≥5: NOHIT, no update, protocol_err.
- protocol_err pulses in the RESP cycle.
- bus_valid while busy is ignored; the bus holds it until bus_ready.
- Back-to-back: a new op can be accepted on the RESP→IDLE edge+1, i.e. minimum 4-cycle spacing.

Decomposition:
- Shared package additions:
  - bus-op enum (READ=1, WRITE=2, INVALIDATE=3, RWIM=4).
  - snoop result constants HIT/HITM/NOHIT (existing).
  - MESI enum (existing M/E/S/I).
  - a packed struct {result, next_state, wb, inval, err}.
- One combinational sub-module `mesi_snoop_next`: (op, hit, state) → that struct. The FSM stays in the top.

Test Plan:
- READ 0x0001_2340 with tag store returning hit, way 5, M, wb_ready tied 1 → wb_valid with wb_addr=0x0001_2340 (offset bits zeroed); snoop_result=1; tag_wr way 5 state S(2); no l1_inval.
- RWIM on an E line, way 2 → snoop_valid at accept+3, result HIT(0), tag_wr state I(3), l1_inval_valid with the line address, no wb_valid.
- INVALIDATE on an M line → result NOHIT(2), protocol_err=1 for one cycle, tag_wr_en stays 0.
- READ on a miss, then a second op held on bus_valid during processing → first NOHIT at accept+3; second accepted only after bus_ready returns; tag_rd_en exactly one pulse per op.
- RWIM on an M line with wb_ready low for 5 cycles → wb_valid and wb_addr stable for 6 cycles; snoop_valid one cycle after the wb handshake.
- Assert rst during WB → all outputs 0 immediately, snoop_result=2, bus_ready=1, no snoop_valid or tag_wr after release.
